// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined ALU: opcodes, control FSM states and
// opcode legality.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_SLT  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_NOR  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_SLTU = 4'b1011;
    localparam logic [3:0] OP_MUL  = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_BUSY = 2'd1,
        ST_DONE     = 2'd2
    } state_e;

    // Legal opcodes form one contiguous range, ADD through MUL.
    function automatic logic is_legal(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_MUL);
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles.
// product_o carries the final value combinationally during the done_o cycle.
module alu_mul_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] acc_sum;
    logic             last;

    // Partial product is the shifted multiplicand gated by the current multiplier LSB.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_partial
        assign partial[gi] = mcand_q[gi] & mplier_q[0];
    end

    assign acc_sum   = acc_q + partial;
    assign last      = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
    assign busy_o    = busy_q;
    assign done_o    = last;
    assign product_o = acc_sum;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start_i) begin
            mcand_d  = a_i;
            mplier_d = b_i;
            acc_d    = '0;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (last) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake: single-cycle ops answer next
// cycle, MUL runs through the iterative multiplier (WIDTH+1 cycles).
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] DR1,
    input  logic [WIDTH-1:0] DR2,
    input  logic [3:0]       ALUControl,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] ALUOutput,
    output logic             Zero,
    output logic             Overflow,
    output logic             Illegal
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic             illegal_q, illegal_d;

    logic             accept;
    logic             take_op;
    logic             mul_start;
    logic             mul_busy;
    logic             mul_done;
    logic [WIDTH-1:0] mul_product;

    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;
    logic             alu_ill;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [SHAMT_W-1:0] shamt;

    assign InReady   = (state_q == ST_IDLE) || ((state_q == ST_DONE) && OutReady);
    assign accept    = InValid && InReady;
    assign OutValid  = (state_q == ST_DONE);
    assign ALUOutput = result_q;
    assign Zero      = zero_q;
    assign Overflow  = ovf_q;
    assign Illegal   = illegal_q;

    assign sum   = DR1 + DR2;
    assign diff  = DR1 - DR2;
    assign shamt = DR2[SHAMT_W-1:0];

    // Single-cycle result path; MUL's value comes from the multiplier instead.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = !is_legal(ALUControl);
        case (ALUControl)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (DR1[WIDTH-1] == DR2[WIDTH-1]) && (sum[WIDTH-1] != DR1[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (DR1[WIDTH-1] != DR2[WIDTH-1]) && (diff[WIDTH-1] != DR1[WIDTH-1]);
            end
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(DR1) < $signed(DR2))};
            OP_AND:  alu_res = DR1 & DR2;
            OP_OR:   alu_res = DR1 | DR2;
            OP_XOR:  alu_res = DR1 ^ DR2;
            OP_NOR:  alu_res = ~(DR1 | DR2);
            OP_SLL:  alu_res = DR1 << shamt;
            OP_SRL:  alu_res = DR1 >> shamt;
            OP_SRA:  alu_res = $signed(DR1) >>> shamt;
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (DR1 < DR2)};
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        illegal_d = illegal_q;
        take_op   = 1'b0;
        mul_start = 1'b0;

        case (state_q)
            ST_IDLE: begin
                take_op = accept;
            end
            ST_MUL_BUSY: begin
                if (mul_busy && mul_done) begin
                    state_d   = ST_DONE;
                    result_d  = mul_product;
                    zero_d    = (mul_product == '0);
                    ovf_d     = 1'b0;
                    illegal_d = 1'b0;
                end
            end
            ST_DONE: begin
                if (OutReady) begin
                    state_d = ST_IDLE;
                    take_op = accept;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A new op can be taken from IDLE or in the same cycle DONE is consumed.
        if (take_op) begin
            if (ALUControl == OP_MUL) begin
                state_d   = ST_MUL_BUSY;
                mul_start = 1'b1;
            end else begin
                state_d   = ST_DONE;
                result_d  = alu_res;
                zero_d    = (alu_res == '0);
                ovf_d     = alu_ovf;
                illegal_d = alu_ill;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            result_q  <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
            illegal_q <= illegal_d;
        end
    end

    alu_mul_iter #(
        .WIDTH (WIDTH),
        .CNT_W (SHAMT_W)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .start_i   (mul_start),
        .a_i       (DR1),
        .b_i       (DR2),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and randomized checks of alu_pipe (WIDTH=32) against an
// arithmetic reference model.
module tb_alu_pipe;

    localparam int W = 32;
    localparam longint MAX_S = 64'sh0000_0000_7FFF_FFFF;
    localparam longint MIN_S = -64'sh0000_0000_8000_0000;

    logic         clk = 1'b0;
    logic         rst;
    logic         InValid;
    logic         InReady;
    logic [W-1:0] DR1;
    logic [W-1:0] DR2;
    logic [3:0]   ALUControl;
    logic         OutValid;
    logic         OutReady;
    logic [W-1:0] ALUOutput;
    logic         Zero;
    logic         Overflow;
    logic         Illegal;

    int checks   = 0;
    int failures = 0;

    alu_pipe #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .InValid    (InValid),
        .InReady    (InReady),
        .DR1        (DR1),
        .DR2        (DR2),
        .ALUControl (ALUControl),
        .OutValid   (OutValid),
        .OutReady   (OutReady),
        .ALUOutput  (ALUOutput),
        .Zero       (Zero),
        .Overflow   (Overflow),
        .Illegal    (Illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: signed overflow judged on the exact integer result.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic v, output logic il);
        longint sa, sb, s;
        logic [63:0] p;
        int sh;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b[4:0]);
        r = 32'd0; v = 1'b0; il = 1'b0;
        case (op)
            4'd1:  begin s = sa + sb; r = a + b; v = (s > MAX_S) || (s < MIN_S); end
            4'd2:  begin s = sa - sb; r = a - b; v = (s > MAX_S) || (s < MIN_S); end
            4'd3:  r = (sa < sb) ? 32'd1 : 32'd0;
            4'd4:  r = a & b;
            4'd5:  r = a | b;
            4'd6:  r = a ^ b;
            4'd7:  r = ~(a | b);
            4'd8:  r = a << sh;
            4'd9:  r = a >> sh;
            4'd10: r = 32'(sa >>> sh);
            4'd11: r = (a < b) ? 32'd1 : 32'd0;
            4'd12: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
            default: il = 1'b1;
        endcase
    endfunction

    task automatic check_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er;
        logic ev, ei;
        model(op, a, b, er, ev, ei);
        check("result", ALUOutput, er);
        check("zero", 32'(Zero), 32'(er == 32'd0));
        check("overflow", 32'(Overflow), 32'(ev));
        check("illegal", 32'(Illegal), 32'(ei));
    endtask

    // Presents one op, then waits (OutReady low) until the result is held.
    task automatic issue_and_wait(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int lat;
        check("in_ready_idle", 32'(InReady), 32'd1);
        InValid = 1'b1; DR1 = a; DR2 = b; ALUControl = op; OutReady = 1'b0;
        @(posedge clk); #1;
        InValid = 1'b0; DR1 = $urandom; DR2 = $urandom; ALUControl = 4'($urandom);
        lat = 1;
        while (!OutValid && lat < 100) begin
            check("in_ready_busy", 32'(InReady), 32'd0);
            InValid = 1'b1;
            @(posedge clk); #1;
            InValid = 1'b0;
            lat++;
        end
        check("out_valid", 32'(OutValid), 32'd1);
        check("latency", 32'(lat), (op == 4'd12) ? 32'd33 : 32'd1);
        check_result(op, a, b);
        $display("txn op=%h a=%h b=%h res=%h z=%0b v=%0b il=%0b lat=%0d",
                 op, a, b, ALUOutput, Zero, Overflow, Illegal, lat);
    endtask

    task automatic consume();
        OutReady = 1'b1;
        @(posedge clk); #1;
        OutReady = 1'b0;
        check("out_valid_cleared", 32'(OutValid), 32'd0);
    endtask

    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        issue_and_wait(op, a, b);
        consume();
    endtask

    initial begin
        logic [31:0] held;
        logic [3:0]  rop;
        logic [31:0] ra, rb;

        rst = 1'b1; InValid = 1'b0; DR1 = '0; DR2 = '0; ALUControl = '0; OutReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(OutValid), 32'd0);
        check("rst_in_ready", 32'(InReady), 32'd1);
        check("rst_result", ALUOutput, 32'd0);
        check("rst_flags", {29'd0, Zero, Overflow, Illegal}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases from the test plan
        do_op(4'd1, 32'h7FFF_FFFF, 32'h0000_0001);
        check("add_ovf_const", ALUOutput, 32'h8000_0000);
        do_op(4'd2, 32'd5, 32'd5);
        do_op(4'd3, 32'hFFFF_FFFF, 32'd1);
        do_op(4'd11, 32'hFFFF_FFFF, 32'd1);
        do_op(4'd10, 32'h8000_0000, 32'd4);
        check("sra_const", ALUOutput, 32'hF800_0000);
        do_op(4'd9, 32'h8000_0000, 32'd4);
        do_op(4'd8, 32'h8000_0000, 32'd4);
        do_op(4'd12, 32'h0001_0003, 32'h0000_0007);
        check("mul_const", ALUOutput, 32'h0007_0015);
        do_op(4'd0, 32'h1234_5678, 32'h9ABC_DEF0);
        do_op(4'd15, 32'h1234_5678, 32'h9ABC_DEF0);

        // Back-pressure: result held, then consume and accept in one cycle
        issue_and_wait(4'd1, 32'h0000_1111, 32'h0000_2222);
        held = ALUOutput;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp_stable_result", ALUOutput, 32'h0000_3333);
            check("bp_out_valid", 32'(OutValid), 32'd1);
            check("bp_in_ready", 32'(InReady), 32'd0);
        end
        OutReady = 1'b1; InValid = 1'b1;
        DR1 = 32'h7000_0000; DR2 = 32'h1000_0000; ALUControl = 4'd1;
        #1;
        check("bp_in_ready_consume", 32'(InReady), 32'd1);
        @(posedge clk); #1;
        InValid = 1'b0; OutReady = 1'b0;
        check("bp_new_valid", 32'(OutValid), 32'd1);
        check("bp_new_differs", 32'(ALUOutput != held), 32'd1);
        check_result(4'd1, 32'h7000_0000, 32'h1000_0000);
        $display("txn op=1 a=70000000 b=10000000 res=%h (back-to-back)", ALUOutput);
        consume();

        // Reset in the middle of a multiply
        InValid = 1'b1; DR1 = 32'h0000_FFFF; DR2 = 32'h0000_FFFF; ALUControl = 4'd12;
        @(posedge clk); #1;
        InValid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("mid_mul_busy", 32'(InReady), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mulrst_out_valid", 32'(OutValid), 32'd0);
        check("mulrst_in_ready", 32'(InReady), 32'd1);
        check("mulrst_result", ALUOutput, 32'd0);
        check("mulrst_flags", {29'd0, Zero, Overflow, Illegal}, 32'd0);
        $display("txn reset during MUL at cycle 10");
        rst = 1'b0;
        @(posedge clk); #1;
        do_op(4'd12, 32'hDEAD_BEEF, 32'h0000_0101);

        // Randomized ops
        for (int n = 0; n < 30; n++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = (n % 3 == 0) ? ra : $urandom;
            do_op(rop, ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
